// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and the hex font for the seven-segment scanner.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_font(input logic [3:0] nibble);
        logic [6:0] pat;
        pat = SEG_OFF;
        case (nibble)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            4'hF: pat = 7'b0001110;
            default: pat = SEG_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_font(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with dead time between
// digits and frame-synchronous update of the displayed value.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 50000,
    parameter int DEAD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] data_in,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              buf_en_n,
    output logic              frame_start
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    state_t            state_q, state_d;
    logic [4*NDIG-1:0] pend_data_q, pend_data_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NDIG-1:0] shadow_data_q, shadow_data_d;
    logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;

    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              buf_en_n_q, buf_en_n_d;
    logic              frame_start_q, frame_start_d;

    logic              cnt_wrap;
    logic              frame_edge;
    logic [3:0]        nib [NDIG];
    logic [NDIG:0]     zero_above;
    logic [3:0]        cur_nib;
    logic [6:0]        font_seg;
    logic              digit_blank;

    // zero_above[k] is set when nibble k and every higher nibble are zero.
    assign zero_above[NDIG] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib[gi]        = shadow_data_q[gi*4 +: 4];
            assign zero_above[gi] = zero_above[gi+1] && (nib[gi] == 4'h0);
        end
    endgenerate

    assign cur_nib     = nib[idx_q];
    assign digit_blank = blank_lz && (idx_q != '0) && zero_above[idx_q];

    hex_to_seg7 u_font (
        .nibble (cur_nib),
        .seg    (font_seg)
    );

    // Scan timing and state.
    always_comb begin
        cnt_wrap   = (cnt_q == CNT_LAST);
        frame_edge = cnt_wrap && (idx_q == IDX_LAST);
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            BLANK:   if (cnt_d == CNT_DEAD) state_d = SHOW;
            SHOW:    if (cnt_wrap)          state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Pending captures every load; shadow takes the pre-edge pending value at the frame boundary.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
        end
        if (frame_edge) begin
            shadow_data_d = pend_data_q;
            shadow_dp_d   = pend_dp_q;
        end
    end

    // Output registers lag the scan state by one cycle, frame_start included.
    always_comb begin
        seg_d         = SEG_OFF;
        dp_d          = 1'b1;
        an_d          = '1;
        buf_en_n_d    = 1'b1;
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
        if (state_q == SHOW) begin
            an_d       = ~(NDIG'(1) << idx_q);
            buf_en_n_d = 1'b0;
            seg_d      = digit_blank ? SEG_OFF : font_seg;
            dp_d       = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            state_q       <= BLANK;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            an_q          <= '1;
            buf_en_n_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            state_q       <= state_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            buf_en_n_q    <= buf_en_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign buf_en_n    = buf_en_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (NDIG=4, DIV=8, DEAD=2).
module tb_seg7_scan_driver;

    localparam int NDIG = 4;
    localparam int DIV  = 8;
    localparam int DEAD = 2;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] SA   = 7'b0001000;
    localparam logic [6:0] SF   = 7'b0001110;
    localparam logic [6:0] SOFF = 7'b1111111;
    localparam logic [13:0] RST_VEC = {1'b0, 4'b1111, 1'b1, 7'b1111111, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        buf_en_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .buf_en_n    (buf_en_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {frame_start, an, buf_en_n, seg, dp};
    endfunction

    task automatic check(input string tag, input logic [13:0] observed, input logic [13:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed {fs,an,buf,seg,dp}=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Checks one 32-cycle frame starting at the negedge where frame_start is expected high.
    // segs = {d3,d2,d1,d0} expected patterns, dps = expected active-low dp per digit.
    task automatic run_frame(input string name, input logic [27:0] segs, input logic [3:0] dps,
                             input int la1, input logic [15:0] d1, input logic [3:0] p1,
                             input int la2, input logic [15:0] d2, input logic [3:0] p2);
        for (int i = 0; i < NDIG * DIV; i++) begin
            int d;
            int c;
            logic [13:0] exp_v;
            d = i / DIV;
            c = i % DIV;
            if (c < DEAD) exp_v = {(i == 0), 4'b1111, 1'b1, SOFF, 1'b1};
            else          exp_v = {1'b0, ~(4'b0001 << d), 1'b0, segs[d*7 +: 7], dps[d]};
            check($sformatf("%s cyc%0d", name, i), obs(), exp_v);
            load = 1'b0;
            if (i == la1) begin load = 1'b1; data_in = d1; dp_in = p1; end
            if (i == la2) begin load = 1'b1; data_in = d2; dp_in = p2; end
            $display("%s cyc%0d an=%b buf=%b seg=%b dp=%b fs=%b", name, i, an, buf_en_n, seg, dp, frame_start);
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset", obs(), RST_VEC);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("zeros", {S0, S0, S0, S0}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("midload", {S0, S0, S0, S0}, 4'b1111, 10, 16'h1A2F, 4'b0100, -1, 16'h0, 4'h0);
        run_frame("show1A2F", {S1, SA, S2, SF}, 4'b1011, 5, 16'h0005, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("show5a", {S0, S0, S0, S5}, 4'b1111, 31, 16'h0008, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("show5b", {S0, S0, S0, S5}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("show8", {S0, S0, S0, S8}, 4'b1111, 5, 16'h0040, 4'b0000, -1, 16'h0, 4'h0);
        blank_lz = 1'b1;
        run_frame("blanklz", {SOFF, SOFF, S4, S0}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        blank_lz = 1'b0;
        repeat (20) @(negedge clk);
        check("digit2 show", obs(), {1'b0, 4'b1011, 1'b0, S0, 1'b1});
        #2 rst_n = 1'b0;
        #1 check("async reset", obs(), RST_VEC);
        $display("async reset an=%b buf=%b seg=%b dp=%b fs=%b", an, buf_en_n, seg, dp, frame_start);
        @(negedge clk);
        check("reset held", obs(), RST_VEC);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame("after rst", {S0, S0, S0, S0}, 4'b1111, 3, 16'h1111, 4'b0000, 4, 16'h2222, 4'b0000);
        run_frame("show2222", {S2, S2, S2, S2}, 4'b1111, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
